// File: rtl/quant_fc_neuron_engine.sv
// quant_fc_neuron_engine: one fully-connected neuron computing an int8-style
// quantized dot product, then requantizing it to a DATA_W-bit output.
//
// Optional feature: define OUTPUT_SAT_EN to saturate the requantized result
// to the signed DATA_W range; otherwise the result is two's-complement truncated.
//
// Ports:
//   i_clk, i_rst               clock (rising edge), synchronous active-high reset
//   i_start                    begin one neuron computation (sampled in IDLE only)
//   i_len                      number of (act, wgt) pairs to consume
//   i_bias                     accumulator start value
//   i_input_zp/i_filter_zp     zero-points subtracted from act/wgt
//   i_output_zp                zero-point added to the requantized result
//   i_quant_mult/i_quant_shift signed requant multiplier and shift (-31..30)
//   i_relu_en                  clamp a negative accumulator to 0 before requant
//   i_in_valid/o_in_ready      operand handshake, i_act/i_wgt operand pair
//   o_out_valid/i_out_ready    result handshake, o_out_data quantized result
//   o_busy                     high whenever not idle
module quant_fc_neuron_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [ACC_W-1:0]  i_bias,
    input  logic [DATA_W-1:0] i_input_zp,
    input  logic [DATA_W-1:0] i_filter_zp,
    input  logic [DATA_W-1:0] i_output_zp,
    input  logic [31:0]       i_quant_mult,
    input  logic [5:0]        i_quant_shift,
    input  logic              i_relu_en,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_act,
    input  logic [DATA_W-1:0] i_wgt,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy
);
    typedef enum logic [2:0] {S_IDLE, S_ACC, S_MUL, S_RND, S_OUT} state_t;

    state_t                r_state, w_next;
    logic [LEN_W-1:0]      r_len, r_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic [DATA_W-1:0]     r_izp, r_fzp, r_ozp, r_out;
    logic [31:0]           r_mult;
    logic [5:0]            r_shift;
    logic                  r_relu;
    logic signed [63:0]    r_p64;

    logic                  w_fire, w_last;
    logic signed [15:0]    w_da, w_dw;
    logic signed [31:0]    w_prod;
    logic [ACC_W-1:0]      w_r;
    logic [6:0]            w_ts;
    logic signed [63:0]    w_round, w_sum;
    logic [DATA_W-1:0]     w_q_out;

    assign o_in_ready  = (r_state == S_ACC);
    assign o_out_valid = (r_state == S_OUT);
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_data  = r_out;

    assign w_fire = o_in_ready && i_in_valid;
    assign w_last = (r_cnt + LEN_W'(1)) == r_len;

    // Zero-point subtraction in 16 bits cannot overflow for DATA_W <= 8 operands
    assign w_da   = 16'($signed(i_act)) - 16'($signed(r_izp));
    assign w_dw   = 16'($signed(i_wgt)) - 16'($signed(r_fzp));
    assign w_prod = 32'(w_da) * 32'(w_dw);

    assign w_r     = (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;
    // Total right shift is 31-shift, i.e. 1..62 over the legal shift range
    assign w_ts    = 7'd31 - 7'($signed(r_shift));
    assign w_round = 64'sd1 <<< (w_ts - 7'd1);
    assign w_sum   = r_p64 + w_round;

`ifdef OUTPUT_SAT_EN
    localparam logic signed [63:0] QMAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [63:0] QMIN = -(64'sd1 <<< (DATA_W - 1));
    logic signed [63:0] w_q;
    assign w_q     = (w_sum >>> w_ts) + 64'($signed(r_ozp));
    assign w_q_out = (w_q > QMAX) ? QMAX[DATA_W-1:0] :
                     (w_q < QMIN) ? QMIN[DATA_W-1:0] : w_q[DATA_W-1:0];
`else
    // Truncation commutes with the add, so only the low bits are formed
    assign w_q_out = DATA_W'(w_sum >>> w_ts) + r_ozp;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_len == '0) ? S_MUL : S_ACC;
            S_ACC:   if (w_fire && w_last) w_next = S_MUL;
            S_MUL:   w_next = S_RND;
            S_RND:   w_next = S_OUT;
            S_OUT:   if (i_out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_izp   <= '0;
            r_fzp   <= '0;
            r_ozp   <= '0;
            r_mult  <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_p64   <= '0;
            r_out   <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_len   <= i_len;
                r_cnt   <= '0;
                r_acc   <= i_bias;
                r_izp   <= i_input_zp;
                r_fzp   <= i_filter_zp;
                r_ozp   <= i_output_zp;
                r_mult  <= i_quant_mult;
                r_shift <= i_quant_shift;
                r_relu  <= i_relu_en;
            end
            if (w_fire) begin
                r_acc <= r_acc + ACC_W'(w_prod);
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (r_state == S_MUL) r_p64 <= 64'($signed(w_r)) * 64'($signed(r_mult));
            if (r_state == S_RND) r_out <= w_q_out;
        end
    end
endmodule

// File: tb/tb_quant_fc_neuron_engine.sv
// tb_quant_fc_neuron_engine: randomized and directed checks against an arithmetic reference model.
module tb_quant_fc_neuron_engine;
    logic       clk = 1'b0;
    logic       rst, start, relu, in_valid, in_ready, out_valid, out_ready, busy;
    logic [9:0] len;
    logic [31:0] bias, mult;
    logic [7:0] izp, fzp, ozp, act, wgt, out_data;
    logic [5:0] shift;

    int n_cmp = 0;
    int n_bad = 0;
    int acts[0:31];
    int wgts[0:31];

    always #5 clk = ~clk;

    quant_fc_neuron_engine dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .i_bias(bias),
        .i_input_zp(izp), .i_filter_zp(fzp), .i_output_zp(ozp),
        .i_quant_mult(mult), .i_quant_shift(shift), .i_relu_en(relu),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_act(act), .i_wgt(wgt),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
        .o_busy(busy)
    );

    function automatic logic [7:0] model(input int n, input int b, input int iz, input int fz,
                                         input int oz, input int m, input int sh, input bit rl);
        int acc;
        int ts;
        longint r, p, q;
        acc = b;
        for (int i = 0; i < n; i++) acc += (acts[i] - iz) * (wgts[i] - fz);
        r = (rl && acc < 0) ? 64'sd0 : longint'(acc);
        p = r * longint'(m);
        ts = 31 - sh;
        q = ((p + (longint'(1) << (ts - 1))) >>> ts) + longint'(oz);
`ifdef OUTPUT_SAT_EN
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
`endif
        return q[7:0];
    endfunction

    task automatic run(input int n, input int b, input int iz, input int fz, input int oz,
                       input int m, input int sh, input bit rl, input bit tog, input int hold,
                       input bit pulse, output logic [7:0] got, output int lat,
                       output int accepted, output bit stable, output bit busy_after);
        int k = 0;
        int g = 0;
        bit v, take;
        @(negedge clk);
        start = 1'b1; len = 10'(n); bias = b; izp = 8'(iz); fzp = 8'(fz); ozp = 8'(oz);
        mult = m; shift = 6'(sh); relu = rl;
        @(negedge clk);
        start = 1'b0; len = 10'($urandom); bias = $urandom; izp = 8'($urandom);
        fzp = 8'($urandom); ozp = 8'($urandom); mult = $urandom; shift = 6'($urandom);
        relu = 1'($urandom);
        while (k < n && g < 200) begin
            v = tog ? (g % 2 == 1) : 1'b1;
            in_valid = v; act = 8'(acts[k]); wgt = 8'(wgts[k]);
            take = v && in_ready;
            @(negedge clk);
            g++;
            if (take) k++;
        end
        in_valid = 1'b0;
        accepted = k;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = out_data;
        stable = out_valid;
        for (int h = 0; h < hold; h++) begin
            start = pulse && (h == 1);
            len = 10'd0;
            @(negedge clk);
            if (!out_valid || out_data !== got) stable = 1'b0;
        end
        start = pulse; out_ready = 1'b1;
        @(negedge clk);
        busy_after = busy | out_valid;
        start = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, busy, out_data} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {in_ready, out_valid, busy, out_data});
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] got; int lat, acc_n; bit st, ba;
        acts[0] = 10; wgts[0] = 3; acts[1] = -4; wgts[1] = 5;
        run(2, 0, 0, 0, 0, 32'h4000_0000, 0, 1'b0, 1'b0, 0, 1'b0, got, lat, acc_n, st, ba);
        n_cmp++;
        if (got !== 8'd5) begin n_bad++; $display("FAIL basic_data: got %0d want 5", got); end
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
        n_cmp++;
        if (ba !== 1'b0) begin n_bad++; $display("FAIL basic_idle_after: got %b want 0", ba); end
    endtask

    task automatic test_relu();
        logic [7:0] got; int lat, acc_n; bit st, ba;
        acts[0] = -4; wgts[0] = 5;
        run(1, 0, 0, 0, -128, 32'h4000_0000, 0, 1'b1, 1'b0, 0, 1'b0, got, lat, acc_n, st, ba);
        n_cmp++;
        if (got !== 8'h80) begin n_bad++; $display("FAIL relu_on: got %h want 80", got); end
        run(1, 0, 0, 0, 3, 32'h4000_0000, 0, 1'b0, 1'b0, 0, 1'b0, got, lat, acc_n, st, ba);
        n_cmp++;
        if (got !== 8'hF9) begin n_bad++; $display("FAIL relu_off: got %h want f9", got); end
    endtask

    task automatic test_sat();
        logic [7:0] got, exp; int lat, acc_n; bit st, ba;
`ifdef OUTPUT_SAT_EN
        exp = 8'd127;
`else
        exp = 8'hF4;
`endif
        run(0, 1000, 0, 0, 0, 32'h4000_0000, 0, 1'b0, 1'b0, 0, 1'b0, got, lat, acc_n, st, ba);
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL len0_sat: got %h want %h", got, exp); end
        n_cmp++;
        if (lat !== 3) begin n_bad++; $display("FAIL len0_latency: got %0d want 3", lat); end
    endtask

    task automatic test_hold();
        logic [7:0] got, exp; int lat, acc_n; bit st, ba;
        for (int i = 0; i < 3; i++) begin
            acts[i] = $urandom_range(0, 255) - 128; wgts[i] = $urandom_range(0, 255) - 128;
        end
        exp = model(3, 77, 5, -3, 9, 32'h2345_6789, -2, 1'b0);
        run(3, 77, 5, -3, 9, 32'h2345_6789, -2, 1'b0, 1'b0, 5, 1'b1, got, lat, acc_n, st, ba);
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL hold_data: got %h want %h", got, exp); end
        n_cmp++;
        if (st !== 1'b1) begin n_bad++; $display("FAIL hold_stable: got %b want 1", st); end
        n_cmp++;
        if (ba !== 1'b0) begin n_bad++; $display("FAIL hold_start_ignored: got %b want 0", ba); end
    endtask

    task automatic test_toggle();
        logic [7:0] g1, g2, exp; int l1, l2, a1, a2; bit st, ba;
        for (int i = 0; i < 4; i++) begin
            acts[i] = $urandom_range(0, 255) - 128; wgts[i] = $urandom_range(0, 255) - 128;
        end
        exp = model(4, -500, 2, 1, 0, 32'h5000_0000, 4, 1'b0);
        run(4, -500, 2, 1, 0, 32'h5000_0000, 4, 1'b0, 1'b1, 0, 1'b0, g1, l1, a1, st, ba);
        run(4, -500, 2, 1, 0, 32'h5000_0000, 4, 1'b0, 1'b0, 0, 1'b0, g2, l2, a2, st, ba);
        n_cmp++;
        if (g1 !== exp) begin n_bad++; $display("FAIL toggle_data: got %h want %h", g1, exp); end
        n_cmp++;
        if (g2 !== exp) begin n_bad++; $display("FAIL stream_data: got %h want %h", g2, exp); end
        n_cmp++;
        if (a1 !== 4 || l1 !== 3) begin
            n_bad++; $display("FAIL toggle_accept: got %0d/%0d want 4/3", a1, l1);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got, exp; int lat, acc_n; bit st, ba;
        for (int i = 0; i < 5; i++) begin
            acts[i] = $urandom_range(0, 255) - 128; wgts[i] = $urandom_range(0, 255) - 128;
        end
        @(negedge clk);
        start = 1'b1; len = 10'd5; bias = 32'd123; izp = 8'd1; fzp = 8'd2; ozp = 8'd3;
        mult = 32'h4000_0000; shift = 6'd0; relu = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; act = 8'(acts[i]); wgt = 8'(wgts[i]);
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, busy, out_data} !== 11'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b want 0", {in_ready, out_valid, busy, out_data});
        end
        rst = 1'b0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
        exp = model(5, 123, 1, 2, 3, 32'h4000_0000, 0, 1'b0);
        run(5, 123, 1, 2, 3, 32'h4000_0000, 0, 1'b0, 1'b0, 0, 1'b0, got, lat, acc_n, st, ba);
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL midreset_rerun: got %h want %h", got, exp); end
    endtask

    task automatic test_random();
        logic [7:0] got, exp; int lat, acc_n, n, b, iz, fz, oz, m, sh; bit rl, tg, st, ba;
        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                acts[i] = $urandom_range(0, 255) - 128; wgts[i] = $urandom_range(0, 255) - 128;
            end
            b = $urandom; iz = $urandom_range(0, 255) - 128; fz = $urandom_range(0, 255) - 128;
            oz = $urandom_range(0, 255) - 128; m = $urandom; sh = $urandom_range(0, 61) - 31;
            rl = 1'($urandom); tg = 1'($urandom);
            exp = model(n, b, iz, fz, oz, m, sh, rl);
            run(n, b, iz, fz, oz, m, sh, rl, tg, $urandom_range(0, 3), 1'b0, got, lat, acc_n, st, ba);
            n_cmp++;
            if (got !== exp || lat !== 3) begin
                n_bad++;
                $display("FAIL random_%0d: got %h lat %0d want %h lat 3", t, got, lat, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; bias = '0; izp = '0; fzp = '0; ozp = '0;
        mult = '0; shift = '0; relu = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        act = '0; wgt = '0;
        test_reset();
        test_basic();
        test_relu();
        test_sat();
        test_hold();
        test_toggle();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
